// File: rtl/user_io_pkg.sv
// Shared definitions for the user_io SPI control channel.
//   - Command byte codes understood by user_io_spi_slave.
//   - Frame state encoding of the SPI responder.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW   = 8'h01;
  localparam logic [7:0] CMD_JOY0     = 8'h02;
  localparam logic [7:0] CMD_JOY1     = 8'h03;
  localparam logic [7:0] CMD_KBD      = 8'h05;
  localparam logic [7:0] CMD_GET_CONF = 8'h14;
  localparam logic [7:0] CMD_STATUS8  = 8'h15;
  localparam logic [7:0] CMD_STATUS32 = 8'h1E;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    PAYLOAD = 2'd2
  } spi_state_t;

endpackage

// File: rtl/user_io_kbd_fifo.sv
// Synchronous FIFO for PS/2 keyboard bytes.
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   push/push_data write request and byte
//   pop            consumer request; honoured only while valid
//   head           byte at the head of the FIFO (0 when empty)
//   valid          FIFO not empty
//   overflow       one-clk pulse when a push is dropped on a full FIFO
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module user_io_kbd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    valid   = (count != '0);
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    head    = valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/user_io_spi_slave.sv
// Guest-side SPI responder for the user_io control channel.
// SPI mode 0, MSB first; pins are oversampled by clk (>= 6x SCK).
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   spi_sck/ss_n/mosi         asynchronous SPI inputs
//   spi_miso, spi_miso_oe     reply data and its enable (high while selected)
//   buttons, switches         OSD buttons / switches          (cmd 0x01)
//   joystick_0, joystick_1    joysticks, active high          (cmd 0x02/0x03)
//   status                    core status word                (cmd 0x15/0x1E)
//   conf_addr, conf_data      configuration-string ROM access (cmd 0x14)
//   kbd_data/valid/ready      keyboard byte FIFO head/handshake (cmd 0x05)
//   kbd_overflow              pulse when a keyboard byte is dropped
module user_io_spi_slave
  import user_io_pkg::*;
#(
  parameter logic [7:0]  CORE_TYPE      = 8'hA4,
  parameter int unsigned CONF_AW        = 10,
  parameter int unsigned KBD_FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               spi_sck,
  input  logic               spi_ss_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  output logic [1:0]         buttons,
  output logic [1:0]         switches,
  output logic [7:0]         joystick_0,
  output logic [7:0]         joystick_1,
  output logic [31:0]        status,
  output logic [CONF_AW-1:0] conf_addr,
  input  logic [7:0]         conf_data,
  output logic [7:0]         kbd_data,
  output logic               kbd_valid,
  input  logic               kbd_ready,
  output logic               kbd_overflow
);

  // Synchronizers and edge detection
  logic [1:0] sck_sync;
  logic [1:0] ss_sync;
  logic [1:0] mosi_sync;
  logic       sck_q;
  logic       ss_q;
  logic       sck_rise;
  logic       sck_fall;
  logic       ss_fall;

  // ss_n chain resets to "selected" so that a frame is only recognised after
  // ss_n has been seen high and then falls again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_q     <= sck_sync[1];
      ss_q      <= ss_sync[1];
    end
  end

  always_comb begin
    sck_rise = sck_sync[1] && !sck_q;
    sck_fall = !sck_sync[1] && sck_q;
    ss_fall  = !ss_sync[1] && ss_q;
  end

  // Frame engine
  spi_state_t   state;
  logic [2:0]   bit_cnt;
  logic [6:0]   rx_sr;
  logic [7:0]   rx_byte;
  logic [7:0]   cmd_q;
  logic [7:0]   byte_idx;
  logic [7:0]   miso_sr;
  logic [1:0]   load_pipe;
  logic [23:0]  status_shadow;
  logic         kbd_push;

  always_comb begin
    rx_byte  = {rx_sr, mosi_sync[1]};
    kbd_push = !ss_sync[1] && (state == PAYLOAD) && sck_rise &&
               (bit_cnt == 3'd7) && (cmd_q == CMD_KBD);
  end

  assign spi_miso = miso_sr[7];

  // The next reply byte is loaded two clks after a byte completes, so that
  // conf_data has had a full clk to follow the new conf_addr. The falling
  // SCK edge that closes a byte (bit_cnt back at 0) must not shift, otherwise
  // the freshly loaded MSB would be lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      cmd_q         <= '0;
      byte_idx      <= '0;
      miso_sr       <= '0;
      load_pipe     <= '0;
      spi_miso_oe   <= 1'b0;
      buttons       <= '0;
      switches      <= '0;
      joystick_0    <= '0;
      joystick_1    <= '0;
      status        <= '0;
      status_shadow <= '0;
      conf_addr     <= '0;
    end else begin
      load_pipe <= {load_pipe[0], 1'b0};
      if (ss_sync[1]) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        miso_sr     <= '0;
        load_pipe   <= '0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state       <= CMD;
              bit_cnt     <= '0;
              miso_sr     <= CORE_TYPE;
              spi_miso_oe <= 1'b1;
            end
          end
          CMD, PAYLOAD: begin
            if (sck_rise) begin
              rx_sr   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                load_pipe <= 2'b01;
                if (state == CMD) begin
                  cmd_q    <= rx_byte;
                  byte_idx <= '0;
                  state    <= PAYLOAD;
                  if (rx_byte == CMD_GET_CONF) conf_addr <= '0;
                end else begin
                  if (byte_idx != 8'hFF) byte_idx <= byte_idx + 8'd1;
                  case (cmd_q)
                    CMD_BUT_SW: begin
                      if (byte_idx == 8'd0) begin
                        switches <= rx_byte[3:2];
                        buttons  <= rx_byte[1:0];
                      end
                    end
                    CMD_JOY0: begin
                      if (byte_idx == 8'd0) joystick_0 <= rx_byte;
                    end
                    CMD_JOY1: begin
                      if (byte_idx == 8'd0) joystick_1 <= rx_byte;
                    end
                    CMD_STATUS8: begin
                      if (byte_idx == 8'd0) status[7:0] <= rx_byte;
                    end
                    CMD_STATUS32: begin
                      case (byte_idx)
                        8'd0:    status_shadow[7:0]   <= rx_byte;
                        8'd1:    status_shadow[15:8]  <= rx_byte;
                        8'd2:    status_shadow[23:16] <= rx_byte;
                        8'd3:    status <= {rx_byte, status_shadow};
                        default: ;
                      endcase
                    end
                    CMD_GET_CONF: conf_addr <= conf_addr + CONF_AW'(1);
                    default: ;
                  endcase
                end
              end
            end else if (load_pipe[1]) begin
              miso_sr <= (cmd_q == CMD_GET_CONF) ? conf_data : '0;
            end else if (sck_fall && (bit_cnt != 3'd0)) begin
              miso_sr <= {miso_sr[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  user_io_kbd_fifo #(
    .DEPTH (KBD_FIFO_DEPTH),
    .WIDTH (8)
  ) u_kbd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (kbd_push),
    .push_data (rx_byte),
    .pop       (kbd_ready),
    .head      (kbd_data),
    .valid     (kbd_valid),
    .overflow  (kbd_overflow)
  );

endmodule

// File: tb/tb_user_io_spi_slave.sv
module tb_user_io_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [1:0]  buttons;
  logic [1:0]  switches;
  logic [7:0]  joystick_0;
  logic [7:0]  joystick_1;
  logic [31:0] status;
  logic [9:0]  conf_addr;
  logic [7:0]  conf_data;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic        kbd_ready = 1'b0;
  logic        kbd_overflow;

  user_io_spi_slave #(
    .CORE_TYPE      (8'hA4),
    .CONF_AW        (10),
    .KBD_FIFO_DEPTH (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_sck      (spi_sck),
    .spi_ss_n     (spi_ss_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .buttons      (buttons),
    .switches     (switches),
    .joystick_0   (joystick_0),
    .joystick_1   (joystick_1),
    .status       (status),
    .conf_addr    (conf_addr),
    .conf_data    (conf_data),
    .kbd_data     (kbd_data),
    .kbd_valid    (kbd_valid),
    .kbd_ready    (kbd_ready),
    .kbd_overflow (kbd_overflow)
  );

  always #5 clk = ~clk;

  // Configuration ROM: data valid one clk after the address
  logic [7:0] rom [0:15];
  always_ff @(posedge clk) conf_data <= rom[conf_addr[3:0]];

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  always @(negedge clk) if (kbd_overflow) ovf_cnt++;

  logic [7:0] tx_buf [0:15];
  logic [7:0] miso_q [$];
  logic [7:0] kbd_q [$];

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  dat;
    int          sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       return 32'({switches, buttons});
      1:       return 32'(joystick_0);
      2:       return 32'(joystick_1);
      default: return status;
    endcase
  endfunction

  // Expected MISO bytes for the first nfull bytes of the frame in tx_buf
  task automatic expect_miso(input int nfull);
    for (int i = 0; i < nfull; i++) begin
      if (i == 0)                  miso_q.push_back(8'hA4);
      else if (tx_buf[0] == 8'h14) miso_q.push_back(rom[i-1]);
      else                         miso_q.push_back(8'h00);
    end
  endtask

  // SCK = clk/8; every pin change lands on a clk falling edge
  task automatic send_frame(input int n, input int last_bits);
    logic [7:0] rx;
    logic [7:0] e;
    @(negedge clk);
    spi_ss_n = 1'b0;
    #80;
    chk("miso_oe_selected", 32'(spi_miso_oe), 32'd1);
    for (int i = 0; i < n; i++) begin
      int nb;
      nb = (i == n - 1) ? last_bits : 8;
      rx = '0;
      for (int k = 0; k < nb; k++) begin
        spi_mosi = tx_buf[i][7-k];
        #40 spi_sck = 1'b1;
        rx[7-k] = spi_miso;
        #40 spi_sck = 1'b0;
      end
      if (nb == 8) begin
        if (miso_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected_byte: got %h expected none", rx);
        end else begin
          e = miso_q.pop_front();
          chk($sformatf("miso_byte%0d", i), 32'(rx), 32'(e));
        end
      end
    end
    #80;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    #80;
    chk("miso_oe_released", 32'(spi_miso_oe), 32'd0);
  endtask

  task automatic drain_kbd(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (kbd_q.size() != 0) ? kbd_q.pop_front() : 8'hxx;
      chk($sformatf("kbd_valid_%0d", i), 32'(kbd_valid), 32'd1);
      chk($sformatf("kbd_data_%0d", i), 32'(kbd_data), 32'(e));
      @(negedge clk) kbd_ready = 1'b1;
      @(negedge clk) kbd_ready = 1'b0;
    end
    chk("kbd_valid_drained", 32'(kbd_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_buttons"},  32'(buttons),     32'd0);
    chk({tag, "_switches"}, 32'(switches),    32'd0);
    chk({tag, "_joy0"},     32'(joystick_0),  32'd0);
    chk({tag, "_joy1"},     32'(joystick_1),  32'd0);
    chk({tag, "_status"},   status,           32'd0);
    chk({tag, "_conf_addr"},32'(conf_addr),   32'd0);
    chk({tag, "_kbd_valid"},32'(kbd_valid),   32'd0);
    chk({tag, "_kbd_data"}, 32'(kbd_data),    32'd0);
    chk({tag, "_kbd_ovf"},  32'(kbd_overflow),32'd0);
    chk({tag, "_miso"},     32'(spi_miso),    32'd0);
    chk({tag, "_miso_oe"},  32'(spi_miso_oe), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h4F; rom[1] = 8'h52; rom[2] = 8'h3B; rom[3] = 8'h49;

    vecs[0] = '{8'h01, 8'h0E, 0, 32'h0000000E};
    vecs[1] = '{8'h02, 8'hA5, 1, 32'h000000A5};
    vecs[2] = '{8'h03, 8'h3C, 2, 32'h0000003C};
    vecs[3] = '{8'h15, 8'h5A, 3, 32'h0000005A};
    vecs[4] = '{8'h07, 8'hFF, 1, 32'h000000A5};
    vecs[5] = '{8'h01, 8'hF5, 0, 32'h00000005};

    #23;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two-byte command table
    for (int v = 0; v < 6; v++) begin
      tx_buf[0] = vecs[v].cmd;
      tx_buf[1] = vecs[v].dat;
      expect_miso(2);
      send_frame(2, 8);
      chk($sformatf("vec%0d_out", v), obs(vecs[v].sel), vecs[v].exp);
    end

    // 32-bit status, atomic update
    tx_buf[0] = 8'h1E; tx_buf[1] = 8'h78; tx_buf[2] = 8'h56;
    tx_buf[3] = 8'h34; tx_buf[4] = 8'h12;
    expect_miso(5);
    send_frame(5, 8);
    chk("status32", status, 32'h12345678);
    tx_buf[0] = 8'h1E; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF;
    expect_miso(3);
    send_frame(3, 8);
    chk("status32_short", status, 32'h12345678);
    tx_buf[0] = 8'h15; tx_buf[1] = 8'h9A;
    expect_miso(2);
    send_frame(2, 8);
    chk("status8_keeps_upper", status, 32'h1234569A);

    // Keyboard stream
    tx_buf[0] = 8'h05; tx_buf[1] = 8'h1C; tx_buf[2] = 8'hF0; tx_buf[3] = 8'h1C;
    kbd_q.push_back(8'h1C); kbd_q.push_back(8'hF0); kbd_q.push_back(8'h1C);
    expect_miso(4);
    send_frame(4, 8);
    drain_kbd(3);

    // Keyboard overflow: 9 bytes into a depth-8 FIFO
    ovf_cnt = 0;
    tx_buf[0] = 8'h05;
    for (int i = 1; i <= 9; i++) begin
      tx_buf[i] = 8'(i * 17);
      if (i <= 8) kbd_q.push_back(8'(i * 17));
    end
    expect_miso(10);
    send_frame(10, 8);
    chk("kbd_overflow_pulses", 32'(ovf_cnt), 32'd1);
    drain_kbd(8);

    // Configuration string readout
    tx_buf[0] = 8'h14;
    for (int i = 1; i <= 4; i++) tx_buf[i] = 8'h00;
    expect_miso(5);
    send_frame(5, 8);
    chk("conf_addr_end", 32'(conf_addr), 32'd4);

    // Truncated joystick payload, then a full one with a trailing extra byte
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h00;
    expect_miso(1);
    send_frame(2, 5);
    chk("joy0_truncated", 32'(joystick_0), 32'h000000A5);
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h81; tx_buf[2] = 8'h55;
    expect_miso(3);
    send_frame(3, 8);
    chk("joy0_full", 32'(joystick_0), 32'h00000081);

    // Asynchronous reset in the middle of a frame
    tx_buf[0] = 8'h05; tx_buf[1] = 8'hAA;
    kbd_q.push_back(8'hAA);
    expect_miso(2);
    send_frame(2, 8);
    chk("kbd_valid_before_reset", 32'(kbd_valid), 32'd1);
    @(negedge clk);
    spi_ss_n = 1'b0;
    #80;
    for (int k = 0; k < 3; k++) begin
      spi_mosi = k[0];
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    kbd_q.delete();
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("kbd_empty_after_reset", 32'(kbd_valid), 32'd0);
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h10;
    expect_miso(2);
    send_frame(2, 8);
    chk("joy1_after_reset", 32'(joystick_1), 32'h00000010);

    chk("miso_scoreboard_drained", 32'(miso_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_io_spi_slave.md
Name: user_io_spi_slave

Overview:
Guest-side SPI responder for the control channel driven by substitute_mcu (spi_toguest/spi_fromguest, selected by conf_data0).
- Decodes command/payload byte streams into buttons, switches, joysticks, 32-bit core status and a PS/2 keyboard byte stream.
- Returns the core-type byte and the core configuration string on MISO.
- Sits inside guest_top and oversamples the SPI pins with the system clock.

Parameters:
CORE_TYPE, 8'hA4, byte shifted out on MISO during every command byte.
CONF_AW, 10, address width of the external configuration-string ROM.
KBD_FIFO_DEPTH, 8, depth of the keyboard byte FIFO (power of two).

Ports:
clk  in  1  system clock; must be ≥ 6× SPI SCK frequency.
reset_n  in  1  asynchronous active-low reset.
spi_sck  in  1  SPI clock from controller (async).
spi_ss_n  in  1  chip select (conf_data0), active low (async).
spi_mosi  in  1  controller→guest data (async).
spi_miso  out  1  guest→controller data.
spi_miso_oe  out  1  1 while selected; the top drives Z otherwise.
buttons  out  2  OSD buttons.
switches  out  2  OSD switches.
joystick_0  out  8  joystick 0, active high.
joystick_1  out  8  joystick 1, active high.
status  out  32  core status word.
conf_addr  out  CONF_AW  configuration-ROM address.
conf_data  in  8  configuration-ROM data, valid one clk after conf_addr.
kbd_data  out  8  FIFO head byte.
kbd_valid  out  1  FIFO not empty.
kbd_ready  in  1  consumer pop; a pop occurs when kbd_valid && kbd_ready.
kbd_overflow  out  1  one-clk pulse when a byte is dropped on a full FIFO.

Behaviour:
- Reset: all outputs 0; spi_miso_oe=0; FIFO empty; state IDLE.
- Input handling: 2-FF synchronizers on sck, ss_n and mosi, followed by registered edge detect.
- SPI framing: mode 0, MSB first. MOSI is sampled on SCK rise; MISO is updated on SCK fall.
- State machine IDLE → CMD → PAYLOAD:
  - ss_n low: enter CMD, bit counter = 0, MISO shift register = CORE_TYPE.
  - ss_n high in any state: return to IDLE, discard any partial byte, spi_miso_oe=0.
  - 8th rising edge in CMD: latch cmd, enter PAYLOAD, byte index = 0.
  - 8th rising edge in PAYLOAD: byte_done. Byte index saturates at 255.
- Output latency: a decoded output updates no later than 4 clk cycles after the completing SCK rise at the pin.
- Command table:
  - 0x01: byte 0 → switches = b[3:2], buttons = b[1:0].
  - 0x02: byte 0 → joystick_0.
  - 0x03: byte 0 → joystick_1.
  - 0x05: every payload byte is pushed to the keyboard FIFO.
  - 0x15: byte 0 → status[7:0]; status[31:8] unchanged.
  - 0x1E: bytes 0..3 go to a shadow register, LSB first. status updates atomically after byte 3. A frame that ends before byte 3 leaves status unchanged.
  - 0x14: conf_addr = 0 at command completion; +1 after each payload byte. MISO for payload byte n = ROM[n], loaded into the shift register ≤ 3 clk after the previous byte_done.
  - Other codes: payload ignored; MISO = 0.
- Extra payload bytes beyond the defined length are ignored, except for 0x05 and 0x14.
- Keyboard FIFO:
  - Push while full: byte dropped, kbd_overflow pulses, contents unchanged.
  - Simultaneous push and pop while full: pop takes effect and the new byte is accepted.
  - Simultaneous push and pop while empty: byte enqueued; kbd_valid rises next cycle.
- Reset mid-frame: state returns to IDLE and the FIFO is cleared. The next frame requires a fresh ss_n falling edge.

Decomposition:
- Package user_io_pkg:
  - command constants CMD_BUT_SW=8'h01, CMD_JOY0=8'h02, CMD_JOY1=8'h03, CMD_KBD=8'h05, CMD_GET_CONF=8'h14, CMD_STATUS8=8'h15, CMD_STATUS32=8'h1E;
  - state enum spi_state_t {IDLE, CMD, PAYLOAD}.
- Sub-module: user_io_kbd_fifo, a synchronous FIFO parameterized by depth, reset by reset_n.

Test Plan:
- Frame {0x01, 0x0E}, SCK = clk/8 → buttons=2'b10, switches=2'b11; MISO returns 0xA4 during the command byte; spi_miso_oe high only while ss_n is low.
- Frame {0x1E, 0x78, 0x56, 0x34, 0x12} → status=32'h12345678 after the last byte. Then frame {0x1E, 0xFF, 0xFF} with ss_n raised early → status stays 32'h12345678.
- Frame {0x05, 0x1C, 0xF0, 0x1C} with kbd_ready=0 → kbd_valid=1 and pops yield 0x1C, 0xF0, 0x1C. Then 9 bytes pushed with ready=0 → exactly one kbd_overflow pulse; 8 bytes retained.
- Frame {0x14, 0x00×4} with ROM "OR;I" → MISO payload bytes 0x4F, 0x52, 0x3B, 0x49; conf_addr ends at 4.
- ss_n raised after 5 bits of a 0x02 payload → joystick_0 unchanged. The following frame {0x02, 0x81} → joystick_0=0x81.
- reset_n asserted low mid-frame (async, between clk edges) → all outputs 0 immediately and FIFO empty. After release, frame {0x03, 0x10} → joystick_1=0x10.
